// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion, flush and hold
module id_ex_stage #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [10:0]       id_opcode,
    input  logic              id_alu_on,
    input  logic              id_sign,
    input  logic [REG_W-1:0]  id_rn,
    input  logic [REG_W-1:0]  id_rm,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_rn_used,
    input  logic              id_rm_used,
    input  logic [DATA_W-1:0] id_da,
    input  logic [DATA_W-1:0] id_db,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              ex_valid,
    output logic [10:0]       ex_opcode,
    output logic              ex_alu_on,
    output logic              ex_sign,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_da,
    output logic [DATA_W-1:0] ex_db,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              stall_id,
    output logic [CNT_W-1:0]  hazard_cnt
);

    // Register 31 is XZR: writes to it are discarded, so it never creates a dependency.
    localparam logic [REG_W-1:0] XZR     = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_LOAD
    } action_t;

    logic    flush_pend;
    logic    eff_flush;
    logic    load_use;
    logic    rn_match;
    logic    rm_match;
    logic    cnt_inc;
    action_t action;

    // Detect a consumer in ID reading the register a load in EX has not yet produced.
    always_comb begin
        rn_match  = id_rn_used && (id_rn == ex_rd);
        rm_match  = id_rm_used && (id_rm == ex_rd);
        load_use  = ex_valid && ex_mem_read && (ex_rd != XZR) && id_valid
                    && (rn_match || rm_match);
        eff_flush = flush || flush_pend;
    end

    // Resolve the per-edge action in priority order: hold, flush, load-use, normal issue.
    always_comb begin
        action   = ACT_BUBBLE;
        stall_id = 1'b0;
        cnt_inc  = 1'b0;
        if (ex_hold) begin
            action   = ACT_HOLD;
            stall_id = 1'b1;
        end else if (eff_flush) begin
            // ID instruction is on the wrong path; let IF/ID advance past it.
            action   = ACT_BUBBLE;
        end else if (load_use) begin
            action   = ACT_BUBBLE;
            stall_id = 1'b1;
            cnt_inc  = (hazard_cnt != CNT_MAX);
        end else if (id_valid) begin
            action   = ACT_LOAD;
        end
    end

    // Remember a flush that arrived while EX was frozen so it applies once the hold lifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_pend <= 1'b0;
        end else if (ex_hold) begin
            if (flush) begin
                flush_pend <= 1'b1;
            end
        end else begin
            flush_pend <= 1'b0;
        end
    end

    // Saturating count of load-use bubbles actually inserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hazard_cnt <= '0;
        end else if (cnt_inc) begin
            hazard_cnt <= hazard_cnt + 1'b1;
        end
    end

    // Pipeline register proper: hold, load a bubble, or capture the ID fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_opcode    <= '0;
            ex_alu_on    <= 1'b0;
            ex_sign      <= 1'b0;
            ex_rd        <= XZR;
            ex_da        <= '0;
            ex_db        <= '0;
            ex_imm       <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else begin
            case (action)
                ACT_LOAD: begin
                    ex_valid     <= 1'b1;
                    ex_opcode    <= id_opcode;
                    ex_alu_on    <= id_alu_on;
                    ex_sign      <= id_sign;
                    ex_rd        <= id_rd;
                    ex_da        <= id_da;
                    ex_db        <= id_db;
                    ex_imm       <= id_imm;
                    ex_reg_write <= id_reg_write;
                    ex_mem_read  <= id_mem_read;
                    ex_mem_write <= id_mem_write;
                end
                ACT_BUBBLE: begin
                    ex_valid     <= 1'b0;
                    ex_opcode    <= '0;
                    ex_alu_on    <= 1'b0;
                    ex_sign      <= 1'b0;
                    ex_rd        <= XZR;
                    ex_da        <= '0;
                    ex_db        <= '0;
                    ex_imm       <= '0;
                    ex_reg_write <= 1'b0;
                    ex_mem_read  <= 1'b0;
                    ex_mem_write <= 1'b0;
                end
                default: begin
                    ex_valid     <= ex_valid;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;

    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [10:0]       id_opcode;
    logic              id_alu_on;
    logic              id_sign;
    logic [REG_W-1:0]  id_rn;
    logic [REG_W-1:0]  id_rm;
    logic [REG_W-1:0]  id_rd;
    logic              id_rn_used;
    logic              id_rm_used;
    logic [DATA_W-1:0] id_da;
    logic [DATA_W-1:0] id_db;
    logic [DATA_W-1:0] id_imm;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              flush;
    logic              ex_hold;
    logic              ex_valid;
    logic [10:0]       ex_opcode;
    logic              ex_alu_on;
    logic              ex_sign;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_da;
    logic [DATA_W-1:0] ex_db;
    logic [DATA_W-1:0] ex_imm;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              stall_id;
    logic [CNT_W-1:0]  hazard_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt;

    id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_alu_on(id_alu_on), .id_sign(id_sign),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
        .id_da(id_da), .id_db(id_db), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_on(ex_alu_on), .ex_sign(ex_sign),
        .ex_rd(ex_rd), .ex_da(ex_da), .ex_db(ex_db), .ex_imm(ex_imm),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .stall_id(stall_id), .hazard_cnt(hazard_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [10:0] op, input logic [4:0] rd,
                          input logic [4:0] rn, input logic rn_u, input logic [4:0] rm,
                          input logic rm_u, input logic [63:0] da, input logic [63:0] db,
                          input logic mrd);
        id_valid     = v;
        id_opcode    = op;
        id_rd        = rd;
        id_rn        = rn;
        id_rn_used   = rn_u;
        id_rm        = rm;
        id_rm_used   = rm_u;
        id_da        = da;
        id_db        = db;
        id_mem_read  = mrd;
        id_reg_write = 1'b1;
        id_alu_on    = 1'b1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_valid"}, 64'(ex_valid), 64'd0);
        check({tag, "_rd"}, 64'(ex_rd), 64'd31);
        check({tag, "_opcode"}, 64'(ex_opcode), 64'd0);
        check({tag, "_mem_read"}, 64'(ex_mem_read), 64'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ex_hold = 1'b0;
        id_sign = 1'b0; id_imm = '0; id_mem_write = 1'b0;
        set_id(1'b0, 11'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 64'd0, 64'd0, 1'b0);
        id_alu_on = 1'b0; id_reg_write = 1'b0;
        #1;
        check_bubble("rst0");
        check("rst0_cnt", 64'(hazard_cnt), 64'd0);
        step();
        step();
        reset = 1'b0;

        // Straight issue of ADDS
        set_id(1'b1, OP_ADDS, 5'd3, 5'd1, 1'b1, 5'd2, 1'b1, 64'd5, 64'd7, 1'b0);
        id_sign = 1'b1; id_imm = 64'h10;
        #1;
        check("adds_stall", 64'(stall_id), 64'd0);
        step();
        check("adds_valid", 64'(ex_valid), 64'd1);
        check("adds_opcode", 64'(ex_opcode), 64'(OP_ADDS));
        check("adds_da", ex_da, 64'd5);
        check("adds_db", ex_db, 64'd7);
        check("adds_rd", 64'(ex_rd), 64'd3);
        check("adds_imm", ex_imm, 64'h10);
        check("adds_sign", 64'(ex_sign), 64'd1);
        check("adds_alu_on", 64'(ex_alu_on), 64'd1);
        id_sign = 1'b0; id_imm = '0;

        // Load-use: LDUR X4 then SUBS reading X4
        set_id(1'b1, OP_LDUR, 5'd4, 5'd1, 1'b1, 5'd0, 1'b0, 64'd0, 64'd0, 1'b1);
        step();
        check("ldur_mem_read", 64'(ex_mem_read), 64'd1);
        set_id(1'b1, OP_SUBS, 5'd6, 5'd4, 1'b1, 5'd5, 1'b1, 64'd9, 64'd2, 1'b0);
        #1;
        check("lu_stall", 64'(stall_id), 64'd1);
        step();
        check_bubble("lu_bubble");
        check("lu_cnt", 64'(hazard_cnt), 64'd1);
        check("lu_stall_after", 64'(stall_id), 64'd0);
        step();
        check("lu_subs_valid", 64'(ex_valid), 64'd1);
        check("lu_subs_opcode", 64'(ex_opcode), 64'(OP_SUBS));
        check("lu_subs_rd", 64'(ex_rd), 64'd6);

        // Same dependency pattern through XZR never stalls
        set_id(1'b1, OP_LDUR, 5'd31, 5'd1, 1'b1, 5'd0, 1'b0, 64'd0, 64'd0, 1'b1);
        step();
        set_id(1'b1, OP_SUBS, 5'd6, 5'd31, 1'b1, 5'd31, 1'b1, 64'd9, 64'd2, 1'b0);
        #1;
        check("xzr_stall", 64'(stall_id), 64'd0);
        step();
        check("xzr_subs_opcode", 64'(ex_opcode), 64'(OP_SUBS));
        check("xzr_cnt", 64'(hazard_cnt), 64'd1);

        // Match on rm only also stalls; flush in the same cycle wins
        set_id(1'b1, OP_LDUR, 5'd4, 5'd1, 1'b1, 5'd0, 1'b0, 64'd0, 64'd0, 1'b1);
        step();
        set_id(1'b1, OP_SUBS, 5'd6, 5'd1, 1'b1, 5'd4, 1'b1, 64'd9, 64'd2, 1'b0);
        #1;
        check("rm_stall", 64'(stall_id), 64'd1);
        flush = 1'b1;
        #1;
        check("flush_lu_stall", 64'(stall_id), 64'd0);
        step();
        flush = 1'b0;
        check_bubble("flush_lu");
        check("flush_lu_cnt", 64'(hazard_cnt), 64'd1);

        // Hold for three cycles with a flush pulsed in the second
        set_id(1'b1, OP_ADDS, 5'd3, 5'd1, 1'b1, 5'd2, 1'b1, 64'd5, 64'd7, 1'b0);
        step();
        set_id(1'b1, OP_SUBS, 5'd6, 5'd1, 1'b1, 5'd2, 1'b1, 64'd9, 64'd2, 1'b0);
        ex_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            flush = (c == 1);
            #1;
            check("hold_stall", 64'(stall_id), 64'd1);
            step();
            check("hold_opcode", 64'(ex_opcode), 64'(OP_ADDS));
            check("hold_rd", 64'(ex_rd), 64'd3);
            check("hold_valid", 64'(ex_valid), 64'd1);
        end
        flush = 1'b0;
        ex_hold = 1'b0;
        #1;
        check("pend_stall", 64'(stall_id), 64'd0);
        step();
        check_bubble("pend_bubble");
        step();
        check("pend_clear_opcode", 64'(ex_opcode), 64'(OP_SUBS));
        check("pend_clear_valid", 64'(ex_valid), 64'd1);

        // id_valid=0 loads a bubble
        id_valid = 1'b0;
        step();
        check_bubble("idle");

        // Counter saturation
        exp_cnt = 1;
        for (int i = 0; i < 17; i++) begin
            set_id(1'b1, OP_LDUR, 5'd4, 5'd1, 1'b1, 5'd0, 1'b0, 64'd0, 64'd0, 1'b1);
            step();
            set_id(1'b1, OP_SUBS, 5'd6, 5'd4, 1'b1, 5'd5, 1'b1, 64'd9, 64'd2, 1'b0);
            step();
            exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
            check("sat_cnt", 64'(hazard_cnt), 64'(exp_cnt));
        end
        check("sat_final", 64'(hazard_cnt), 64'd15);

        // Asynchronous reset in the middle of a cycle
        set_id(1'b1, OP_ADDS, 5'd3, 5'd1, 1'b1, 5'd2, 1'b1, 64'd5, 64'd7, 1'b0);
        step();
        check("pre_rst_valid", 64'(ex_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_bubble("rst_mid");
        check("rst_mid_da", ex_da, 64'd0);
        check("rst_mid_alu_on", 64'(ex_alu_on), 64'd0);
        check("rst_mid_reg_write", 64'(ex_reg_write), 64'd0);
        check("rst_mid_cnt", 64'(hazard_cnt), 64'd0);
        step();
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
